// File: rtl/ifu_axi_fetch.sv
// Instruction fetch unit: issues one AXI4-Lite read per instruction and hands the word to decode.
// Redirects arriving after a read has been issued are deferred until that read's response drains.
module ifu_axi_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  // AXI4-Lite read address channel
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  // AXI4-Lite read data channel
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  // AXI4-Lite write channels (unused by fetch)
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  // Decode-side handshake
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_fault,
  output logic        out_valid,
  input  logic        out_ready,
  // Redirect from execute
  input  logic        redir_valid,
  input  logic [31:0] redir_target
);

  typedef enum logic [1:0] {
    StIdle,
    StAr,
    StR,
    StOut
  } state_e;

  state_e      r_state;
  logic [31:0] r_pc;
  logic        r_discard;
  logic [31:0] r_pend;
  logic [31:0] r_out_pc;
  logic [31:0] r_out_inst;
  logic        r_out_fault;

  state_e      w_state_d;
  logic [31:0] w_pc_d;
  logic        w_discard_d;
  logic [31:0] w_pend_d;
  logic [31:0] w_out_pc_d;
  logic [31:0] w_out_inst_d;
  logic        w_out_fault_d;

  logic        w_ar_fire;
  logic        w_r_fire;
  logic        w_out_fire;
  logic        w_resp_err;

  assign arvalid   = (r_state == StAr);
  assign rready    = (r_state == StR);
  assign out_valid = (r_state == StOut);
  assign araddr    = r_pc;
  assign out_pc    = r_out_pc;
  assign out_inst  = r_out_inst;
  assign out_fault = r_out_fault;

  assign awaddr  = 32'h0;
  assign awvalid = 1'b0;
  assign wdata   = 32'h0;
  assign wstrb   = 4'h0;
  assign wvalid  = 1'b0;
  assign bready  = 1'b1;

  logic w_unused;
  assign w_unused = ^{awready, wready, bresp, bvalid};

  assign w_ar_fire  = arvalid && arready;
  assign w_r_fire   = rready && rvalid;
  assign w_out_fire = out_valid && out_ready;
  assign w_resp_err = (rresp != 2'b00);

  always_comb begin
    w_state_d     = r_state;
    w_pc_d        = r_pc;
    w_discard_d   = r_discard;
    w_pend_d      = r_pend;
    w_out_pc_d    = r_out_pc;
    w_out_inst_d  = r_out_inst;
    w_out_fault_d = r_out_fault;

    case (r_state)
      StIdle: begin
        w_state_d = StAr;
        if (redir_valid) begin
          w_pc_d = redir_target;
        end
      end

      StAr: begin
        // araddr is already on the bus, so the redirect waits for this read to drain
        if (redir_valid) begin
          w_discard_d = 1'b1;
          w_pend_d    = redir_target;
        end
        if (w_ar_fire) begin
          w_state_d = StR;
        end
      end

      StR: begin
        if (w_r_fire) begin
          if (redir_valid) begin
            w_pc_d      = redir_target;
            w_discard_d = 1'b0;
            w_state_d   = StAr;
          end else if (r_discard) begin
            w_pc_d      = r_pend;
            w_discard_d = 1'b0;
            w_state_d   = StAr;
          end else begin
            w_out_pc_d    = r_pc;
            w_out_inst_d  = w_resp_err ? 32'h0 : rdata;
            w_out_fault_d = w_resp_err;
            w_state_d     = StOut;
          end
        end else if (redir_valid) begin
          w_discard_d = 1'b1;
          w_pend_d    = redir_target;
        end
      end

      StOut: begin
        // A redirect beats pc+4 even when the handshake completes this cycle
        if (redir_valid) begin
          w_pc_d    = redir_target;
          w_state_d = StAr;
        end else if (w_out_fire) begin
          w_pc_d    = r_pc + 32'd4;
          w_state_d = StAr;
        end
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_pc        <= RESET_PC;
      r_discard   <= 1'b0;
      r_pend      <= 32'h0;
      r_out_pc    <= 32'h0;
      r_out_inst  <= 32'h0;
      r_out_fault <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_pc        <= w_pc_d;
      r_discard   <= w_discard_d;
      r_pend      <= w_pend_d;
      r_out_pc    <= w_out_pc_d;
      r_out_inst  <= w_out_inst_d;
      r_out_fault <= w_out_fault_d;
    end
  end

endmodule

// File: tb/tb_ifu_axi_fetch.sv
// Directed bench for ifu_axi_fetch: the bench acts as the AXI slave and the decode stage.
module tb_ifu_axi_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready = 1'b1;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b1;
  logic [1:0]  bresp = 2'b11;
  logic        bvalid = 1'b1;
  logic        bready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_fault;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_target = 32'h0;

  int n_vec = 0;
  int n_err = 0;
  int unsigned cyc = 0;

  ifu_axi_fetch #(.RESET_PC(32'h8000_0000)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .out_pc(out_pc), .out_inst(out_inst), .out_fault(out_fault),
    .out_valid(out_valid), .out_ready(out_ready),
    .redir_valid(redir_valid), .redir_target(redir_target)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got running expected finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    int          ar_w;
    int          r_w;
    logic [1:0]  resp;
    logic [31:0] data;
    int          rdy_w;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        fault;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic vec_t ok(input logic [31:0] a, input logic [31:0] d);
    vec_t v;
    v.ar_w = 0; v.r_w = 0; v.resp = 2'b00; v.data = d; v.rdy_w = 0;
    v.addr = a; v.inst = d; v.fault = 1'b0;
    return v;
  endfunction

  // Waits (bounded) for a read request; decode must see nothing meanwhile.
  task automatic wait_ar(input logic [31:0] exp_addr);
    int   n;
    logic saw;
    n   = 0;
    saw = out_valid;
    while (!arvalid && n < 20) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
      n++;
    end
    chk1("no_stray_out_valid", saw, 1'b0);
    chk1("arvalid_seen", arvalid, 1'b1);
    chk("araddr", araddr, exp_addr);
  endtask

  task automatic ar_phase(input int w, input logic [31:0] a);
    arready = 1'b0;
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      chk("araddr_hold", araddr, a);
      chk1("arvalid_hold", arvalid, 1'b1);
    end
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk1("rready", rready, 1'b1);
  endtask

  task automatic r_phase(input int w, input logic [1:0] resp, input logic [31:0] data);
    for (int i = 0; i < w; i++) @(negedge clk);
    rvalid = 1'b1;
    rresp  = resp;
    rdata  = data;
    @(negedge clk);
    rvalid = 1'b0;
    rresp  = 2'b00;
    rdata  = 32'h0;
  endtask

  task automatic fetch_to_out(input vec_t v);
    int unsigned t0;
    wait_ar(v.addr);
    t0 = cyc;
    ar_phase(v.ar_w, v.addr);
    r_phase(v.r_w, v.resp, v.data);
    chk("latency", cyc - t0, 32'(2 + v.ar_w + v.r_w));
    chk1("out_valid", out_valid, 1'b1);
    chk("out_pc", out_pc, v.addr);
    chk("out_inst", out_inst, v.inst);
    chk1("out_fault", out_fault, v.fault);
  endtask

  task automatic out_phase(input vec_t v);
    out_ready = 1'b0;
    for (int i = 0; i < v.rdy_w; i++) begin
      @(negedge clk);
      chk1("out_valid_hold", out_valid, 1'b1);
      chk("out_pc_hold", out_pc, v.addr);
      chk("out_inst_hold", out_inst, v.inst);
      chk1("out_fault_hold", out_fault, v.fault);
      chk1("arvalid_low_in_out", arvalid, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_fetch(input vec_t v);
    fetch_to_out(v);
    out_phase(v);
  endtask

  task automatic chk_reset_outputs();
    chk1("rst_arvalid", arvalid, 1'b0);
    chk1("rst_rready", rready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk1("rst_out_fault", out_fault, 1'b0);
  endtask

  initial begin
    vecs[0] = '{0, 0, 2'b00, 32'h0000_0013, 0, 32'h8000_0000, 32'h0000_0013, 1'b0};
    vecs[1] = '{1, 2, 2'b00, 32'h00a0_0093, 5, 32'h8000_0004, 32'h00a0_0093, 1'b0};
    vecs[2] = '{0, 0, 2'b10, 32'hdead_beef, 0, 32'h8000_0008, 32'h0000_0000, 1'b1};
    vecs[3] = '{3, 1, 2'b00, 32'h1234_5678, 2, 32'h8000_000c, 32'h1234_5678, 1'b0};
    vecs[4] = '{0, 1, 2'b11, 32'hffff_ffff, 1, 32'h8000_0010, 32'h0000_0000, 1'b1};
    vecs[5] = '{2, 0, 2'b01, 32'h0000_0073, 0, 32'h8000_0014, 32'h0000_0000, 1'b1};

    repeat (2) @(negedge clk);
    chk_reset_outputs();
    chk("write_chan_ctrl", {25'b0, awvalid, wvalid, bready, wstrb}, 32'h0000_0010);
    chk("write_chan_data", awaddr | wdata, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) do_fetch(vecs[i]);

    // Redirect while waiting for read data: response is dropped
    wait_ar(32'h8000_0018);
    ar_phase(0, 32'h8000_0018);
    redir_valid  = 1'b1;
    redir_target = 32'h8000_0100;
    @(negedge clk);
    redir_valid = 1'b0;
    rvalid      = 1'b1;
    rdata       = 32'hbad0_0001;
    @(negedge clk);
    rvalid = 1'b0;
    do_fetch(ok(32'h8000_0100, 32'h0000_0513));

    // arready withheld 4 cycles with a redirect on the third
    wait_ar(32'h8000_0104);
    arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      redir_valid  = (i == 2);
      redir_target = 32'h8000_0200;
      @(negedge clk);
      chk("araddr_hold_redir", araddr, 32'h8000_0104);
      chk1("arvalid_hold_redir", arvalid, 1'b1);
    end
    redir_valid = 1'b0;
    arready     = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    rvalid  = 1'b1;
    rdata   = 32'hbad0_0002;
    @(negedge clk);
    rvalid = 1'b0;
    do_fetch(ok(32'h8000_0200, 32'h0000_0593));

    // Redirect on the same cycle as the read response
    wait_ar(32'h8000_0204);
    ar_phase(0, 32'h8000_0204);
    rvalid       = 1'b1;
    rdata        = 32'hbad0_0003;
    redir_valid  = 1'b1;
    redir_target = 32'h8000_0300;
    @(negedge clk);
    rvalid      = 1'b0;
    redir_valid = 1'b0;
    do_fetch(ok(32'h8000_0300, 32'h0000_0613));

    // Back-to-back redirects while a discard is pending: latest wins
    wait_ar(32'h8000_0304);
    ar_phase(0, 32'h8000_0304);
    redir_valid  = 1'b1;
    redir_target = 32'h8000_0400;
    @(negedge clk);
    redir_target = 32'h8000_0500;
    @(negedge clk);
    redir_valid = 1'b0;
    rvalid      = 1'b1;
    rdata       = 32'hbad0_0004;
    @(negedge clk);
    rvalid = 1'b0;
    do_fetch(ok(32'h8000_0500, 32'h0000_0693));

    // Redirect in OUT without fire; out_valid must not react combinationally
    fetch_to_out(ok(32'h8000_0504, 32'h0000_0713));
    redir_valid  = 1'b1;
    redir_target = 32'h8000_0600;
    #1;
    chk1("out_valid_no_comb", out_valid, 1'b1);
    @(negedge clk);
    redir_valid = 1'b0;
    chk1("out_valid_drop", out_valid, 1'b0);
    do_fetch(ok(32'h8000_0600, 32'h0000_0793));

    // Redirect coinciding with fire: redirect target beats pc+4
    fetch_to_out(ok(32'h8000_0604, 32'h0000_0813));
    redir_valid  = 1'b1;
    redir_target = 32'h8000_0700;
    out_ready    = 1'b1;
    @(negedge clk);
    redir_valid = 1'b0;
    out_ready   = 1'b0;
    do_fetch(ok(32'h8000_0700, 32'h0000_0893));

    // PC wrap at the top of the address space
    fetch_to_out(ok(32'h8000_0704, 32'h0000_0913));
    redir_valid  = 1'b1;
    redir_target = 32'hffff_fffc;
    @(negedge clk);
    redir_valid = 1'b0;
    do_fetch(ok(32'hffff_fffc, 32'h0000_0993));
    do_fetch(ok(32'h0000_0000, 32'h0000_0a13));

    // Reset in the middle of a read aborts and restarts from RESET_PC
    wait_ar(32'h0000_0004);
    ar_phase(0, 32'h0000_0004);
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    do_fetch(ok(32'h8000_0000, 32'h0000_0013));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
